serial_magnitude_comparator: RTL and testbench

Multi-cycle, parametrised magnitude comparator for wide operands. It compares two WIDTH-bit operands CHUNK bits per cycle, most-significant chunk first, and supports unsigned and two's-complement modes. An optional early exit ends the comparison at the first differing chunk. It sits beside the single-cycle narrow comparators in the datapath and is used where wide operands make a flat compare too slow for the clock.

---
 rtl/cmp_pkg.sv | 15 +
 rtl/chunk_cmp.sv | 16 +
 rtl/serial_magnitude_comparator.sv | 138 +++++++++++++
 tb/tb_serial_magnitude_comparator.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/cmp_pkg.sv
// Shared types for the serial magnitude comparator: FSM state and result flags.
package cmp_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    typedef struct packed {
        logic greater;
        logic equal;
        logic less;
    } flags_t;

endpackage

// File: rtl/chunk_cmp.sv
// Combinational unsigned magnitude compare of one CHUNK-bit slice.
module chunk_cmp #(
    parameter int unsigned CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    output logic             gt,
    output logic             eq,
    output logic             lt
);

    assign gt = (a > b);
    assign eq = (a == b);
    assign lt = (a < b);

endmodule

// File: rtl/serial_magnitude_comparator.sv
// Multi-cycle WIDTH-bit magnitude comparator scanning CHUNK bits per cycle, MSB chunk first.
module serial_magnitude_comparator
    import cmp_pkg::*;
#(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned CHUNK      = 4,
    parameter int unsigned EARLY_EXIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic             A_greater,
    output logic             A_equal,
    output logic             A_less
);

    localparam int unsigned N  = WIDTH / CHUNK;
    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             dec_valid_q, dec_valid_d;
    logic             dec_gt_q, dec_gt_d;
    flags_t           flags_q, flags_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    int unsigned      sh;
    logic [CHUNK-1:0] chunk_a, chunk_b;
    logic             gt, eq, lt;
    logic             last;
    logic             cur_gt, cur_lt, cur_diff;
    logic [WIDTH-1:0] sign_flip;

    // Select chunk[idx] of the latched operands; chunk 0 is the MSB chunk.
    always_comb begin
        sh      = (N - 1 - 32'(idx_q)) * CHUNK;
        chunk_a = CHUNK'(a_q >> sh);
        chunk_b = CHUNK'(b_q >> sh);
    end

    chunk_cmp #(.CHUNK(CHUNK)) u_chunk_cmp (
        .a  (chunk_a),
        .b  (chunk_b),
        .gt (gt),
        .eq (eq),
        .lt (lt)
    );

    assign last      = (idx_q == IW'(N - 1));
    assign sign_flip = {signed_mode, {(WIDTH-1){1'b0}}};

    // A sticky decision from an earlier chunk overrides the current chunk.
    assign cur_diff = dec_valid_q | ~eq;
    assign cur_gt   = dec_valid_q ? dec_gt_q  : gt;
    assign cur_lt   = dec_valid_q ? ~dec_gt_q : lt;

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        idx_d       = idx_q;
        dec_valid_d = dec_valid_q;
        dec_gt_d    = dec_gt_q;
        flags_d     = flags_q;
        busy_d      = busy_q;
        done_d      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    // Offset-binary view turns the signed compare into an unsigned one.
                    a_d         = A ^ sign_flip;
                    b_d         = B ^ sign_flip;
                    idx_d       = '0;
                    dec_valid_d = 1'b0;
                    dec_gt_d    = 1'b0;
                    busy_d      = 1'b1;
                    state_d     = RUN;
                end
            end
            RUN: begin
                if (((EARLY_EXIT != 0) && !eq) || last) begin
                    flags_d.greater = cur_diff & cur_gt;
                    flags_d.equal   = ~cur_diff;
                    flags_d.less    = cur_diff & cur_lt;
                    done_d          = 1'b1;
                    busy_d          = 1'b0;
                    state_d         = IDLE;
                end else begin
                    idx_d = idx_q + IW'(1);
                    if (!eq && !dec_valid_q) begin
                        dec_valid_d = 1'b1;
                        dec_gt_d    = gt;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            idx_q       <= '0;
            dec_valid_q <= 1'b0;
            dec_gt_q    <= 1'b0;
            flags_q     <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            idx_q       <= idx_d;
            dec_valid_q <= dec_valid_d;
            dec_gt_q    <= dec_gt_d;
            flags_q     <= flags_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign A_greater = flags_q.greater;
    assign A_equal   = flags_q.equal;
    assign A_less    = flags_q.less;

endmodule

// File: tb/tb_serial_magnitude_comparator.sv
// Bench: early-exit and full-scan comparators driven in parallel, checked against an arithmetic model.
module tb_serial_magnitude_comparator;

    localparam int unsigned W = 16;
    localparam int unsigned C = 4;
    localparam int unsigned N = W / C;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         sm;
    logic [W-1:0] a;
    logic [W-1:0] b;

    logic busy_e, done_e, gt_e, eq_e, lt_e;
    logic busy_f, done_f, gt_f, eq_f, lt_f;

    int checks = 0;
    int errors = 0;

    logic [2:0] prev_e;
    logic [2:0] prev_f;

    always #5 clk = ~clk;

    serial_magnitude_comparator #(.WIDTH(W), .CHUNK(C), .EARLY_EXIT(1)) dut_e (
        .clk(clk), .rst(rst), .start(start), .signed_mode(sm), .A(a), .B(b),
        .busy(busy_e), .done(done_e), .A_greater(gt_e), .A_equal(eq_e), .A_less(lt_e)
    );

    serial_magnitude_comparator #(.WIDTH(W), .CHUNK(C), .EARLY_EXIT(0)) dut_f (
        .clk(clk), .rst(rst), .start(start), .signed_mode(sm), .A(a), .B(b),
        .busy(busy_f), .done(done_f), .A_greater(gt_f), .A_equal(eq_f), .A_less(lt_f)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected {greater, equal, less} from plain integer arithmetic.
    function automatic logic [2:0] ref_flags(input logic [W-1:0] xa, input logic [W-1:0] xb,
                                             input logic xs);
        int va, vb;
        if (xs) begin
            va = int'($signed(xa));
            vb = int'($signed(xb));
        end else begin
            va = int'(xa);
            vb = int'(xb);
        end
        if (va > vb) return 3'b100;
        if (va == vb) return 3'b010;
        return 3'b001;
    endfunction

    // Index of the first differing chunk from the MSB end, N when all equal.
    function automatic int first_diff(input logic [W-1:0] xa, input logic [W-1:0] xb);
        int da, db;
        for (int c = 0; c < int'(N); c++) begin
            da = (int'(xa) >> (int'(W) - int'(C) * (c + 1))) & ((1 << C) - 1);
            db = (int'(xb) >> (int'(W) - int'(C) * (c + 1))) & ((1 << C) - 1);
            if (da != db) return c;
        end
        return int'(N);
    endfunction

    task automatic chk_all(input string tag, input int i, input int le, input int lf);
        chk({tag, " busy_e"}, 32'(busy_e), 32'(i < le));
        chk({tag, " done_e"}, 32'(done_e), 32'(i == le));
        chk({tag, " flags_e"}, 32'({gt_e, eq_e, lt_e}), 32'(prev_e));
        chk({tag, " busy_f"}, 32'(busy_f), 32'(i < lf));
        chk({tag, " done_f"}, 32'(done_f), 32'(i == lf));
        chk({tag, " flags_f"}, 32'({gt_f, eq_f, lt_f}), 32'(prev_f));
    endtask

    // One compare on both DUTs; operands scrambled after accept, optional ignored start.
    task automatic run_cmp(input string tag, input logic [W-1:0] xa, input logic [W-1:0] xb,
                           input logic xs, input bit junk);
        logic [2:0] exp;
        int k, le, lf;
        exp = ref_flags(xa, xb, xs);
        k   = first_diff(xa, xb);
        le  = (k == int'(N)) ? int'(N) : k + 1;
        lf  = int'(N);
        a = xa; b = xb; sm = xs; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk_all({tag, " e0"}, 0, le + 1, lf + 1);
        for (int i = 1; i <= lf; i++) begin
            if (i == 1) begin
                a  = W'($urandom);
                b  = W'($urandom);
                sm = 1'($urandom);
                if (junk && le >= 3) start = 1'b1;
            end
            @(posedge clk); #1;
            start = 1'b0;
            if (i == le) prev_e = exp;
            if (i == lf) prev_f = exp;
            chk_all(tag, i, le, lf);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            chk_all("idle", 1, 0, 0);
        end
    endtask

    initial begin
        logic [W-1:0] ra, rb;
        int mode;

        rst = 1'b1; start = 1'b0; sm = 1'b0; a = '0; b = '0;
        prev_e = '0; prev_f = '0;
        #1;
        chk_all("reset", 1, 0, 0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        idle(1);

        run_cmp("eq1234", 16'h1234, 16'h1234, 1'b0, 1'b1);
        idle(2);
        run_cmp("u8000", 16'h8000, 16'h7FFF, 1'b0, 1'b0);
        idle(1);
        run_cmp("s8000", 16'h8000, 16'h7FFF, 1'b1, 1'b0);
        idle(1);
        run_cmp("k3", 16'h12F0, 16'h12F1, 1'b0, 1'b1);
        idle(1);
        run_cmp("f000", 16'hF000, 16'h0FFF, 1'b0, 1'b0);
        idle(1);
        // Second start lands in the done cycle of the first.
        run_cmp("b2b_a", 16'hABCD, 16'hABCD, 1'b0, 1'b0);
        run_cmp("b2b_5_9", 16'h0005, 16'h0009, 1'b0, 1'b1);
        idle(1);

        // Reset two cycles into a compare aborts it with no done pulse.
        a = 16'h1234; b = 16'h1235; sm = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        prev_e = '0; prev_f = '0;
        chk_all("rst_mid", 1, 0, 0);
        @(negedge clk) rst = 1'b0;
        idle(2);
        run_cmp("post_rst0", 16'h0000, 16'h0000, 1'b0, 1'b0);
        idle(1);

        for (int t = 0; t < 40; t++) begin
            ra   = W'($urandom);
            mode = int'($urandom_range(0, 2));
            if (mode == 0) rb = ra;
            else if (mode == 1) rb = W'($urandom);
            else rb = ra ^ (W'($urandom_range(1, 15)) << (C * $urandom_range(0, N - 1)));
            run_cmp("rand", ra, rb, 1'($urandom), 1'($urandom));
            idle(int'($urandom_range(0, 2)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
